line_buf_stream: RTL and testbench

LINE_BUF_STREAM -- requirements
Module: line_buf_stream

---
 rtl/line_buf_stream.sv | 107 ++++++++++
 tb/tb_line_buf_stream.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/line_buf_stream.sv
// line_buf_stream: streaming line buffer that emits vertical pixel columns for windowed filters
module line_buf_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS = 3,
  parameter int ROW_WIDTH = 640,
  localparam int AW = $clog2(ROW_WIDTH),
  localparam int LW = $clog2(ROW_WIDTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LW-1:0]              line_width,
  input  logic                       sof,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ROWS*DATA_WIDTH-1:0] out_data,
  output logic [AW-1:0]              out_col,
  output logic                       out_eol,
  output logic                       primed
);
  localparam int RW = (ROWS > 2) ? $clog2(ROWS - 1) : 1;
  localparam int SW = $clog2(ROWS);
  logic [DATA_WIDTH-1:0]      r_mem [ROWS-1][ROW_WIDTH];
  logic [AW-1:0]              r_col;
  logic [RW-1:0]              r_wr_row;
  logic [SW-1:0]              r_rows_seen;
  logic [LW-1:0]              r_eff_width;
  logic                       r_out_valid;
  logic [ROWS*DATA_WIDTH-1:0] r_out_data;
  logic [AW-1:0]              r_out_col;
  logic                       r_out_eol;
  logic                       w_accept;
  logic [AW-1:0]              w_col;
  logic [RW-1:0]              w_row;
  logic [RW-1:0]              w_next_row;
  logic [SW-1:0]              w_seen;
  logic [LW-1:0]              w_width;
  logic                       w_last;
  logic                       w_primed_now;
  logic [ROWS*DATA_WIDTH-1:0] w_column;

  assign in_ready  = !r_out_valid || out_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_col   = r_out_col;
  assign out_eol   = r_out_eol;
  assign primed    = (r_rows_seen == SW'(ROWS - 1));

  // Position of the incoming pixel: a start-of-frame pixel restarts the frame before it is placed
  always_comb begin
    w_accept     = in_valid && in_ready;
    w_col        = sof ? '0 : r_col;
    w_row        = sof ? '0 : r_wr_row;
    w_seen       = sof ? '0 : r_rows_seen;
    w_width      = sof ? ((line_width == '0 || line_width > LW'(ROW_WIDTH)) ? LW'(ROW_WIDTH) : line_width) : r_eff_width;
    w_last       = (LW'(w_col) == w_width - LW'(1));
    w_primed_now = (w_seen == SW'(ROWS - 1));
    w_next_row   = (w_row == RW'(ROWS - 2)) ? '0 : w_row + RW'(1);
  end

  // Column assembly: newest pixel in slice 0, older banks read before this pixel overwrites the oldest
  always_comb begin
    w_column = '0;
    w_column[DATA_WIDTH-1:0] = in_data;
    for (int j = 1; j < ROWS; j++)
      w_column[j*DATA_WIDTH +: DATA_WIDTH] = r_mem[RW'((int'(w_row) + ROWS - 1 - j) % (ROWS - 1))][w_col];
  end

  // Line banks hold pixel history only, so they are never reset
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[w_row][w_col] <= in_data;
  end

  // Write pointer, bank rotation and priming progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col       <= '0;
      r_wr_row    <= '0;
      r_rows_seen <= '0;
      r_eff_width <= LW'(ROW_WIDTH);
    end else if (w_accept) begin
      r_col       <= w_last ? '0 : w_col + AW'(1);
      r_wr_row    <= w_last ? w_next_row : w_row;
      r_rows_seen <= (w_last && !w_primed_now) ? w_seen + SW'(1) : w_seen;
      r_eff_width <= w_width;
    end
  end

  // Output register: loads only on acceptance, which implies the previous column has left
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_col   <= '0;
      r_out_eol   <= 1'b0;
    end else if (w_accept && w_primed_now) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_column;
      r_out_col   <= w_col;
      r_out_eol   <= w_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_line_buf_stream.sv
// tb_line_buf_stream: scoreboard bench for line_buf_stream with ROWS=3, ROW_WIDTH=5
module tb_line_buf_stream;
  localparam int DW = 8;
  localparam int R  = 3;
  localparam int RWID = 5;
  localparam int AW = 3;
  localparam int LW = 3;

  logic clk = 0;
  logic rst = 0;
  logic [LW-1:0] line_width = '0;
  logic sof = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [DW-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1;
  logic [R*DW-1:0] out_data;
  logic [AW-1:0] out_col;
  logic out_eol;
  logic primed;

  line_buf_stream #(.DATA_WIDTH(DW), .ROWS(R), .ROW_WIDTH(RWID)) dut (
    .clk(clk), .rst(rst), .line_width(line_width), .sof(sof),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col(out_col), .out_eol(out_eol), .primed(primed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    bit          s;
    logic [2:0]  lw;
    bit          exp_primed;
    bit          exp_out;
    logic [27:0] exp;
  } vec_t;

  vec_t tbl[20];
  int n_cmp = 0;
  int n_bad = 0;
  logic [27:0] sb[$];
  logic [27:0] mon_e;
  logic [23:0] cap;
  bit tbl_mode = 0;
  int m_row = 0, m_col = 0, m_w = 5;
  logic [7:0] hist[0:63][0:4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: full frame history, column = the two previous lines above the new pixel
  task automatic model_accept(input logic [7:0] d, input bit s, input logic [2:0] lw);
    if (s) begin
      m_row = 0;
      m_col = 0;
      m_w = (lw == 0 || lw > 5) ? 5 : int'(lw);
    end
    hist[m_row][m_col] = d;
    if (m_row >= 2 && !tbl_mode)
      sb.push_back({hist[m_row-2][m_col], hist[m_row-1][m_col], d, 3'(m_col), 1'(m_col == m_w - 1)});
    if (m_col == m_w - 1) begin
      m_col = 0;
      m_row++;
    end else m_col++;
  endtask

  task automatic send(input logic [7:0] d, input bit s, input logic [2:0] lw);
    in_valid = 1; in_data = d; sof = s; line_width = lw;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(d, s, lw);
        @(posedge clk); #1;
        in_valid = 0; sof = 0;
        return;
      end
      @(posedge clk); #1;
    end
    n_cmp++; n_bad++;
    $display("FAIL send_timeout: pixel %0h not accepted within 50 cycles", d);
    in_valid = 0; sof = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sb.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_queue_empty", sb.size(), 0);
  endtask

  task automatic run_table();
    tbl_mode = 1;
    for (int i = 0; i < 20; i++) begin
      if (tbl[i].exp_out) sb.push_back(tbl[i].exp);
      send(tbl[i].d, tbl[i].s, tbl[i].lw);
      check("primed_after_pixel", primed, tbl[i].exp_primed);
    end
    tbl_mode = 0;
    drain();
  endtask

  // Scoreboard monitor: a column transfers on the next rising edge when valid and ready at the falling edge
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_column: got %h col %0d expected none", out_data, out_col);
      end else begin
        mon_e = sb.pop_front();
        check("column", {4'b0, out_data, out_col, out_eol}, {4'b0, mon_e});
      end
    end
  end

  initial begin
    for (int i = 0; i < 20; i++) begin
      tbl[i].d = 8'(i);
      tbl[i].s = (i == 0);
      tbl[i].lw = 3'd5;
      tbl[i].exp_primed = (i >= 9);
      tbl[i].exp_out = (i >= 10);
      tbl[i].exp = {8'(i - 10), 8'(i - 5), 8'(i), 3'(i % 5), 1'(i % 5 == 4)};
    end
    #12;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_primed", primed, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_data", out_data, 0);
    check("reset_out_col", out_col, 0);
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #1;
    run_table();
    for (int i = 0; i < 9; i++) send(8'(i), i == 0, 3'd3);
    drain();
    for (int i = 0; i < 15; i++) send(8'(i + 100), i == 0, 3'd0);
    drain();
    for (int i = 0; i < 15; i++) send(8'(i + 120), i == 0, 3'd7);
    drain();
    for (int i = 0; i < 10; i++) send(8'(i + 50), i == 0, 3'd5);
    drain();
    out_ready = 0;
    fork
      for (int i = 10; i < 15; i++) send(8'(i + 50), 0, 3'd5);
      begin
        @(posedge clk); #1;
        cap = out_data;
        check("bp_out_valid", out_valid, 1);
        repeat (4) begin
          @(negedge clk);
          check("bp_in_ready_low", in_ready, 0);
          check("bp_data_stable", out_data, cap);
        end
        @(posedge clk); #1 out_ready = 1;
      end
    join
    drain();
    for (int i = 0; i < 12; i++) send(8'(i + 150), i == 0, 3'd5);
    check("midsof_primed_before", primed, 1);
    send(8'd200, 1, 3'd5);
    check("midsof_primed_dropped", primed, 0);
    for (int i = 1; i < 10; i++) begin
      send(8'(200 + i), 0, 3'd5);
      check("midsof_primed_refill", primed, i == 9);
    end
    for (int i = 10; i < 15; i++) send(8'(200 + i), 0, 3'd5);
    drain();
    out_ready = 0;
    for (int i = 0; i < 11; i++) send(8'(i + 30), i == 0, 3'd5);
    check("rst_pre_out_valid", out_valid, 1);
    #3 rst = 0;
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_primed", primed, 0);
    check("rst_async_in_ready", in_ready, 1);
    sb.delete();
    m_row = 0; m_col = 0; m_w = 5;
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #1;
    out_ready = 1;
    run_table();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
